// File: rtl/in_buf_fft16_if.sv
// rtl/in_buf_fft16_if.sv - mapper/FFT16 side bundle for the ping-pong input buffer
interface in_buf_fft16_if #(
   parameter int DOUBLE_DATA_WIDTH = 32
);
   logic                         i_valid_in_buf_fft16;
   logic [DOUBLE_DATA_WIDTH-1:0] i_data_in_buf_fft16;
   logic                         o_ready_in_buf_fft16;
   logic                         i_flush_in_buf_fft16;
   logic                         i_frame_ack_in_buf_fft16;
   logic                         o_frame_valid_in_buf_fft16;
   logic [DOUBLE_DATA_WIDTH-1:0] o_data_in_buf_fft16 [16];
   logic [3:0]                   o_fill_cnt_in_buf_fft16;
   logic                         o_overflow_in_buf_fft16;

   // Buffer side
   modport slave (
      input  i_valid_in_buf_fft16, i_data_in_buf_fft16, i_flush_in_buf_fft16,
             i_frame_ack_in_buf_fft16,
      output o_ready_in_buf_fft16, o_frame_valid_in_buf_fft16, o_data_in_buf_fft16,
             o_fill_cnt_in_buf_fft16, o_overflow_in_buf_fft16
   );

   // Mapper / FFT16 side
   modport master (
      output i_valid_in_buf_fft16, i_data_in_buf_fft16, i_flush_in_buf_fft16,
             i_frame_ack_in_buf_fft16,
      input  o_ready_in_buf_fft16, o_frame_valid_in_buf_fft16, o_data_in_buf_fft16,
             o_fill_cnt_in_buf_fft16, o_overflow_in_buf_fft16
   );
endinterface

// File: rtl/in_buf_fft16.sv
// rtl/in_buf_fft16.sv - two-bank 16-sample ping-pong input buffer feeding the FFT16
// Optional macro IN_BUF_FFT16_BITREV_EN: store sample k at index bitrev4(k).
module in_buf_fft16 #(
   parameter int DATA_WIDTH        = 16,
   parameter int DOUBLE_DATA_WIDTH = 2 * DATA_WIDTH
) (
   input  logic          i_clk_in_buf_fft16,
   input  logic          i_rst_n,
   in_buf_fft16_if.slave bus
);

   logic [DOUBLE_DATA_WIDTH-1:0] r_bank [2][16];
   logic       r_wr_bank;
   logic       r_rd_bank;
   logic [3:0] r_cnt;
   logic [1:0] r_full;
   logic       r_overflow;

   logic       w_ready;
   logic       w_frame_valid;
   logic       w_accept;
   logic       w_ack;
   logic       w_last;
   logic [3:0] w_wr_idx;
   logic [1:0] w_full_nxt;

   assign w_ready       = ~r_full[r_wr_bank];
   assign w_frame_valid = r_full[r_rd_bank];
   // Flush wins over a sample offered in the same cycle
   assign w_accept      = bus.i_valid_in_buf_fft16 & w_ready & ~bus.i_flush_in_buf_fft16;
   assign w_ack         = bus.i_frame_ack_in_buf_fft16 & w_frame_valid;
   assign w_last        = w_accept & (r_cnt == 4'd15);

`ifdef IN_BUF_FFT16_BITREV_EN
   assign w_wr_idx = {r_cnt[0], r_cnt[1], r_cnt[2], r_cnt[3]};
`else
   assign w_wr_idx = r_cnt;
`endif

   // Completion and ack never hit the same bank: accept needs the write bank
   // empty, ack needs the read bank full.
   always_comb begin
      w_full_nxt = r_full;
      if (w_last)
         w_full_nxt[r_wr_bank] = 1'b1;
      if (w_ack)
         w_full_nxt[r_rd_bank] = 1'b0;
   end

   // Pointer, count, full-flag and overflow state
   always_ff @(posedge i_clk_in_buf_fft16 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_bank  <= 1'b0;
         r_rd_bank  <= 1'b0;
         r_cnt      <= 4'd0;
         r_full     <= 2'b00;
         r_overflow <= 1'b0;
      end else if (bus.i_flush_in_buf_fft16) begin
         r_wr_bank  <= 1'b0;
         r_rd_bank  <= 1'b0;
         r_cnt      <= 4'd0;
         r_full     <= 2'b00;
         r_overflow <= 1'b0;
      end else begin
         r_full <= w_full_nxt;
         if (w_accept)
            r_cnt <= r_cnt + 4'd1;
         if (w_last)
            r_wr_bank <= ~r_wr_bank;
         if (w_ack)
            r_rd_bank <= ~r_rd_bank;
         if (bus.i_valid_in_buf_fft16 && !w_ready)
            r_overflow <= 1'b1;
      end
   end

   // Sample storage; flush leaves contents alone, reset clears them
   always_ff @(posedge i_clk_in_buf_fft16 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int b = 0; b < 2; b++)
            for (int k = 0; k < 16; k++)
               r_bank[b][k] <= '0;
      end else if (w_accept) begin
         r_bank[r_wr_bank][w_wr_idx] <= bus.i_data_in_buf_fft16;
      end
   end

   assign bus.o_ready_in_buf_fft16       = w_ready;
   assign bus.o_frame_valid_in_buf_fft16 = w_frame_valid;
   assign bus.o_fill_cnt_in_buf_fft16    = r_cnt;
   assign bus.o_overflow_in_buf_fft16    = r_overflow;

   for (genvar g = 0; g < 16; g++) begin : g_out
      assign bus.o_data_in_buf_fft16[g] = r_bank[r_rd_bank][g];
   end

endmodule

// File: tb/tb_in_buf_fft16.sv
// tb/tb_in_buf_fft16.sv - directed scoreboard bench for in_buf_fft16
module tb_in_buf_fft16;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   logic [31:0] exp_q [$];
   logic [31:0] first_s;

   in_buf_fft16_if #(.DOUBLE_DATA_WIDTH(32)) bus ();

   in_buf_fft16 #(.DATA_WIDTH(16), .DOUBLE_DATA_WIDTH(32)) dut (
      .i_clk_in_buf_fft16 (clk),
      .i_rst_n            (rst_n),
      .bus                (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic int perm(input int j);
      logic [3:0] v;
      v = j[3:0];
`ifdef IN_BUF_FFT16_BITREV_EN
      return int'({v[0], v[1], v[2], v[3]});
`else
      return int'(v);
`endif
   endfunction

   function automatic logic [31:0] pat(input int k);
      logic [15:0] re;
      logic [15:0] im;
      re = 16'(k) << 8;
      im = 16'd0 - 16'(k);
      return {re, im};
   endfunction

   // Drive n samples back-to-back with valid held high; each one is expected to be accepted
   task automatic send(input int n, input bit use_pat);
      logic [31:0] d;
      for (int i = 0; i < n; i++) begin
         d = use_pat ? pat(i) : $urandom;
         bus.i_valid_in_buf_fft16 = 1'b1;
         bus.i_data_in_buf_fft16  = d;
         exp_q.push_back(d);
         @(posedge clk); #1;
      end
      bus.i_valid_in_buf_fft16 = 1'b0;
   endtask

   task automatic pulse_ack();
      bus.i_frame_ack_in_buf_fft16 = 1'b1;
      @(posedge clk); #1;
      bus.i_frame_ack_in_buf_fft16 = 1'b0;
   endtask

   // Compare the presented frame against the oldest 16 scoreboard entries, then retire them
   task automatic check_frame(input string tag);
      chk({tag, "_qsize"}, 32'(exp_q.size() >= 16), 32'd1);
      if (exp_q.size() >= 16) begin
         for (int j = 0; j < 16; j++)
            chk($sformatf("%s_d%0d", tag, j), bus.o_data_in_buf_fft16[j], exp_q[perm(j)]);
         for (int j = 0; j < 16; j++)
            void'(exp_q.pop_front());
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.i_valid_in_buf_fft16     = 1'b0;
      bus.i_data_in_buf_fft16      = '0;
      bus.i_flush_in_buf_fft16     = 1'b0;
      bus.i_frame_ack_in_buf_fft16 = 1'b0;
      #2;
      chk("rst_ready",  32'(bus.o_ready_in_buf_fft16), 32'd1);
      chk("rst_fv",     32'(bus.o_frame_valid_in_buf_fft16), 32'd0);
      chk("rst_fill",   32'(bus.o_fill_cnt_in_buf_fft16), 32'd0);
      chk("rst_ovf",    32'(bus.o_overflow_in_buf_fft16), 32'd0);
      chk("rst_d0",     bus.o_data_in_buf_fft16[0], 32'd0);
      chk("rst_d15",    bus.o_data_in_buf_fft16[15], 32'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Spurious ack while nothing is presented
      pulse_ack();
      chk("spur_fv", 32'(bus.o_frame_valid_in_buf_fft16), 32'd0);

      // Single patterned frame
      send(15, 1'b1);
      chk("sf_fv15",   32'(bus.o_frame_valid_in_buf_fft16), 32'd0);
      chk("sf_fill15", 32'(bus.o_fill_cnt_in_buf_fft16), 32'd15);
      exp_q.delete();
      for (int i = 0; i < 15; i++) exp_q.push_back(pat(i));
      bus.i_valid_in_buf_fft16 = 1'b1;
      bus.i_data_in_buf_fft16  = pat(15);
      exp_q.push_back(pat(15));
      @(posedge clk); #1;
      bus.i_valid_in_buf_fft16 = 1'b0;
      chk("sf_fv",    32'(bus.o_frame_valid_in_buf_fft16), 32'd1);
      chk("sf_fill0", 32'(bus.o_fill_cnt_in_buf_fft16), 32'd0);
      chk("sf_ready", 32'(bus.o_ready_in_buf_fft16), 32'd1);
`ifdef IN_BUF_FFT16_BITREV_EN
      chk("sf_d5", bus.o_data_in_buf_fft16[5], 32'h0A00FFF6);
`else
      chk("sf_d5", bus.o_data_in_buf_fft16[5], 32'h0500FFFB);
`endif
      check_frame("sf");
      pulse_ack();
      chk("sf_ack_fv", 32'(bus.o_frame_valid_in_buf_fft16), 32'd0);

      // Back-pressure: two frames with no ack, then a dropped 33rd sample
      send(32, 1'b0);
      chk("bp_ready", 32'(bus.o_ready_in_buf_fft16), 32'd0);
      chk("bp_fv",    32'(bus.o_frame_valid_in_buf_fft16), 32'd1);
      chk("bp_ovf0",  32'(bus.o_overflow_in_buf_fft16), 32'd0);
      bus.i_valid_in_buf_fft16 = 1'b1;
      bus.i_data_in_buf_fft16  = 32'hDEADBEEF;
      @(posedge clk); #1;
      bus.i_valid_in_buf_fft16 = 1'b0;
      chk("bp_ovf1",  32'(bus.o_overflow_in_buf_fft16), 32'd1);
      chk("bp_fill",  32'(bus.o_fill_cnt_in_buf_fft16), 32'd0);
      check_frame("bp1");
      pulse_ack();
      chk("bp_ready_ack", 32'(bus.o_ready_in_buf_fft16), 32'd1);
      chk("bp_fv_ack",    32'(bus.o_frame_valid_in_buf_fft16), 32'd1);
      check_frame("bp2");
      pulse_ack();
      chk("bp_fv_end",    32'(bus.o_frame_valid_in_buf_fft16), 32'd0);

      // Ack of frame A coincides with the 16th sample of frame B
      send(16, 1'b0);
      check_frame("simA");
      send(15, 1'b0);
      bus.i_frame_ack_in_buf_fft16 = 1'b1;
      send(1, 1'b0);
      bus.i_frame_ack_in_buf_fft16 = 1'b0;
      chk("sim_fv",    32'(bus.o_frame_valid_in_buf_fft16), 32'd1);
      chk("sim_ready", 32'(bus.o_ready_in_buf_fft16), 32'd1);
      check_frame("simB");
      pulse_ack();

      // Flush mid-frame, with valid and ack asserted alongside it
      send(7, 1'b0);
      exp_q.delete();
      chk("fl_fill7", 32'(bus.o_fill_cnt_in_buf_fft16), 32'd7);
      chk("fl_ovf_pre", 32'(bus.o_overflow_in_buf_fft16), 32'd1);
      bus.i_flush_in_buf_fft16     = 1'b1;
      bus.i_valid_in_buf_fft16     = 1'b1;
      bus.i_frame_ack_in_buf_fft16 = 1'b1;
      bus.i_data_in_buf_fft16      = 32'h12345678;
      @(posedge clk); #1;
      bus.i_flush_in_buf_fft16     = 1'b0;
      bus.i_valid_in_buf_fft16     = 1'b0;
      bus.i_frame_ack_in_buf_fft16 = 1'b0;
      chk("fl_fill", 32'(bus.o_fill_cnt_in_buf_fft16), 32'd0);
      chk("fl_ovf",  32'(bus.o_overflow_in_buf_fft16), 32'd0);
      chk("fl_fv",   32'(bus.o_frame_valid_in_buf_fft16), 32'd0);
      send(16, 1'b0);
      first_s = exp_q[0];
      chk("fl_fv16", 32'(bus.o_frame_valid_in_buf_fft16), 32'd1);
      chk("fl_d0",   bus.o_data_in_buf_fft16[0], first_s);
      check_frame("fl");
      pulse_ack();

      // Asynchronous reset mid-frame
      send(7, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rm_fill",  32'(bus.o_fill_cnt_in_buf_fft16), 32'd0);
      chk("rm_fv",    32'(bus.o_frame_valid_in_buf_fft16), 32'd0);
      chk("rm_ready", 32'(bus.o_ready_in_buf_fft16), 32'd1);
      chk("rm_d0",    bus.o_data_in_buf_fft16[0], 32'd0);
      exp_q.delete();
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      send(16, 1'b0);
      first_s = exp_q[0];
      chk("rm_fv16", 32'(bus.o_frame_valid_in_buf_fft16), 32'd1);
      chk("rm_d0_post", bus.o_data_in_buf_fft16[0], first_s);
      check_frame("rm");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/in_buf_fft16.md
IN_BUF_FFT16 -- requirements
Module: in_buf_fft16

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of each real and each imaginary part.
REQ-002 Parameter DOUBLE_DATA_WIDTH, default 32: packed complex word, {real[31:16], imag[15:0]}.
REQ-003 i_clk_in_buf_fft16  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_valid_in_buf_fft16  input  1  input sample valid.
REQ-006 i_data_in_buf_fft16  input  DOUBLE_DATA_WIDTH  signed complex sample from the mapper.
REQ-007 o_ready_in_buf_fft16  output  1  buffer can accept a sample this cycle.
REQ-008 i_flush_in_buf_fft16  input  1  synchronous clear of all pointers and flags.
REQ-009 i_frame_ack_in_buf_fft16  input  1  single-cycle pulse: the FFT16 datapath has consumed the presented frame.
REQ-010 o_frame_valid_in_buf_fft16  output  1  a complete 16-sample frame is presented.
REQ-011 o_data_in_buf_fft16 [15:0]  output  DOUBLE_DATA_WIDTH each  presented frame; feeds the FFT16 datapath parallel input.
REQ-012 o_fill_cnt_in_buf_fft16  output  4  number of samples already written into the current write bank (0..15).
REQ-013 o_overflow_in_buf_fft16  output  1  sticky flag: a sample was offered while not ready.

Function
REQ-014 The block SHALL hold two 16-entry banks (ping-pong) and track a write-bank pointer, a read-bank pointer, a 4-bit write count and one full flag per bank.
REQ-015 o_ready SHALL equal NOT full[wr_bank], as a purely combinational function of registered state.
REQ-016 A sample SHALL be accepted only when valid and ready are both high; it is written to bank[wr_bank][cnt], and cnt increments.
REQ-017 When the sample accepted has cnt = 15, the block SHALL set full[wr_bank], toggle wr_bank, and wrap cnt to 0, all on the same edge.
REQ-018 o_frame_valid SHALL equal full[rd_bank]; it SHALL be high in the cycle immediately after the edge that accepted the 16th sample (latency 1 cycle).
REQ-019 o_data[k] SHALL be driven from bank[rd_bank][k] and SHALL remain stable while o_frame_valid is high.
REQ-020 When i_frame_ack is high and o_frame_valid is high, the block SHALL clear full[rd_bank] and toggle rd_bank. An ack while o_frame_valid is low SHALL be ignored.
REQ-021 Frame completion and ack in the same cycle SHALL both take effect, because they target different banks.
REQ-022 With both banks full, o_ready SHALL be 0. An ack in that state SHALL make o_ready 1 on the next cycle.
REQ-023 If valid is high while ready is low, the sample SHALL be dropped and o_overflow SHALL be set; it stays set until reset or flush.
REQ-024 i_flush SHALL zero cnt, wr_bank, rd_bank, the full flags and o_overflow, and SHALL take priority over valid and ack in the same cycle. Bank contents SHALL be left unchanged.
REQ-025 o_fill_cnt SHALL equal cnt.
REQ-026 No arithmetic SHALL be applied to the data; samples pass through bit-exact.

Reset
REQ-027 Assertion of i_rst_n low SHALL immediately zero all pointers, cnt, the full flags, o_overflow and both banks.
REQ-028 During reset: o_ready = 1, o_frame_valid = 0, o_fill_cnt = 0, o_overflow = 0, and all o_data = 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame. The first sample after release SHALL be written to bank 0, index 0.

Configuration
REQ-030 With macro IN_BUF_FFT16_BITREV_EN defined, the sample with input index k SHALL be stored at index bitrev4(k), so o_data[j] = sample bitrev4(j).
REQ-031 With IN_BUF_FFT16_BITREV_EN undefined, storage SHALL be in natural order: o_data[k] = sample k. Handshake timing SHALL be identical in both builds.

Verification
REQ-032 Single frame: send samples k = 0..15 with data = {k*16'h0100, -k}, valid held high -> o_frame_valid rises one cycle after the 16th sample; o_data[5] = {16'h0500, 16'hFFFB} (natural order) or o_data[5] = sample 10 = {16'h0A00, 16'hFFF6} (BITREV build).
REQ-033 Back-pressure: send 32 samples with no ack -> o_ready falls after sample 32. A 33rd valid sets o_overflow = 1, and the sample is dropped. One ack -> o_ready = 1 the next cycle, and the second frame is presented.
REQ-034 Simultaneous events: ack frame A in the same cycle that frame B's 16th sample is accepted -> next cycle o_frame_valid = 1 with frame B, and o_ready = 1.
REQ-035 Spurious ack: pulse ack with o_frame_valid = 0 -> no change to rd_bank; the next completed frame appears from bank 0.
REQ-036 Flush/reset mid-frame: after 7 samples, assert flush (or reset) -> o_fill_cnt = 0, o_overflow = 0, o_frame_valid = 0. The next 16 samples form a frame whose o_data[0] equals the first post-flush sample.
